// File: rtl/misr_sig_checker.sv
// misr_sig_checker
//   Compacts WINDOW valid response beats into a WIDTH-bit MISR signature and
//   compares the result against a golden value. Reports the outcome through a
//   start/done handshake.
//
//   Ports:
//     clk      - clock, all state on posedge
//     rst      - asynchronous active-low reset
//     start    - begin a new window (accepted in IDLE only)
//     abort    - cancel the window in progress (RUN or CMP)
//     din_vld  - din carries a beat this cycle
//     din      - response word
//     exp_sig  - golden signature, sampled in the compare cycle
//     busy     - high while in RUN or CMP
//     done     - one-cycle pulse after a compare
//     pass     - signature matched at last compare, held until next start
//     fail     - signature mismatched at last compare, held until next start
//     sig      - current signature register
//     err_cnt  - saturating count of failed windows
//
//   Build option: define SIGCHK_ERR_CNT_EN to include the failed-window
//   counter; otherwise err_cnt is tied to zero.
module misr_sig_checker #(
    parameter int unsigned      WIDTH  = 6,
    parameter logic [WIDTH-1:0] TAPS   = 6'b110000,
    parameter logic [WIDTH-1:0] SEED   = 6'b000001,
    parameter int unsigned      WINDOW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             din_vld,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] exp_sig,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [WIDTH-1:0] sig,
    output logic [7:0]       err_cnt
);

    localparam int unsigned     CW        = $clog2(WINDOW + 1);
    localparam logic [CW-1:0]   LAST_BEAT = CW'(WINDOW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_CMP
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic             mismatch;
    logic [WIDTH-1:0] sig_next;

    // One MISR step: shift left, feedback parity into bit 0, fold in din.
    always_comb begin
        sig_next = {sig_q[WIDTH-2:0], ^(sig_q & TAPS)} ^ din;
    end

    always_comb begin
        state_d    = state_q;
        sig_d      = sig_q;
        beat_cnt_d = beat_cnt_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        fail_d     = fail_q;
        mismatch   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // abort takes precedence over a simultaneous start
                if (start && !abort) begin
                    state_d    = S_RUN;
                    sig_d      = SEED;
                    beat_cnt_d = '0;
                    pass_d     = 1'b0;
                    fail_d     = 1'b0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (din_vld) begin
                    sig_d      = sig_next;
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d = S_CMP;
                    end
                end
            end
            S_CMP: begin
                state_d = S_IDLE;
                if (!abort) begin
                    mismatch = (sig_q != exp_sig);
                    pass_d   = !mismatch;
                    fail_d   = mismatch;
                    done_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            sig_q      <= SEED;
            beat_cnt_q <= '0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sig_q      <= sig_d;
            beat_cnt_q <= beat_cnt_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
        end
    end

`ifdef SIGCHK_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (mismatch && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

    assign busy = (state_q == S_RUN) || (state_q == S_CMP);
    assign done = done_q;
    assign pass = pass_q;
    assign fail = fail_q;
    assign sig  = sig_q;

endmodule

// File: tb/tb_misr_sig_checker.sv
// tb_misr_sig_checker
//   Directed bench for misr_sig_checker with WIDTH=6, TAPS=6'b110000,
//   SEED=6'b000001, WINDOW=4. Expected signatures are hand-derived:
//     din=0 x4  : 01 -> 02 -> 04 -> 08 -> 10
//     din=01 x4 : 01 -> 03 -> 07 -> 0F -> 1F
module tb_misr_sig_checker;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       din_vld;
    logic [5:0] din;
    logic [5:0] exp_sig;
    logic       busy;
    logic       done;
    logic       pass;
    logic       fail;
    logic [5:0] sig;
    logic [7:0] err_cnt;

    int total = 0;
    int bad   = 0;
    int fails = 0;

    misr_sig_checker #(
        .WIDTH  (6),
        .TAPS   (6'b110000),
        .SEED   (6'b000001),
        .WINDOW (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .din_vld (din_vld),
        .din     (din),
        .exp_sig (exp_sig),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .fail    (fail),
        .sig     (sig),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] err_exp(input int n);
`ifdef SIGCHK_ERR_CNT_EN
        return (n > 255) ? 8'hFF : 8'(n);
`else
        return 8'h00;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one full window and leaves the bench in the done cycle.
    task automatic run_window(input logic [5:0] d, input logic [5:0] e,
                              input logic [5:0] s, input logic p);
        exp_sig = e;
        din     = d;
        din_vld = 1'b0;
        start   = 1'b1;
        step();
        start = 1'b0;
        chk("win_busy_run", busy, 1'b1);
        chk("win_pass_clr", pass, 1'b0);
        chk("win_fail_clr", fail, 1'b0);
        chk("win_sig_seed", sig, 6'h01);
        chk("win_done_lo", done, 1'b0);
        din_vld = 1'b1;
        repeat (4) step();
        chk("win_sig_final", sig, s);
        chk("win_busy_cmp", busy, 1'b1);
        chk("win_done_cmp", done, 1'b0);
        step();               // CMP cycle with din_vld still high: beat ignored
        din_vld = 1'b0;
        if (!p) fails++;
        chk("win_done", done, 1'b1);
        chk("win_pass", pass, p);
        chk("win_fail", fail, !p);
        chk("win_busy_idle", busy, 1'b0);
        chk("win_sig_hold", sig, s);
        chk("win_err_cnt", err_cnt, err_exp(fails));
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        abort   = 1'b0;
        din_vld = 1'b0;
        din     = '0;
        exp_sig = '0;
        #1 rst = 1'b0;
        #1;
        chk("rst_sig", sig, 6'h01);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass, 1'b0);
        chk("rst_fail", fail, 1'b0);
        chk("rst_err", err_cnt, 8'h00);
        repeat (2) step();
        rst = 1'b1;
        step();

        // 1: zero response, matching golden
        run_window(6'h00, 6'h10, 6'h10, 1'b1);
        step();
        chk("t1_done_pulse", done, 1'b0);
        chk("t1_pass_held", pass, 1'b1);

        // 2: all-ones-in-bit0 response, mismatching golden
        run_window(6'h01, 6'h10, 6'h1F, 1'b0);
        step();
        chk("t2_fail_held", fail, 1'b1);
        chk("t2_pass_held", pass, 1'b0);

        // 3: gaps between beats and a start pulse while running
        exp_sig = 6'h10;
        din     = 6'h01;
        start   = 1'b1;
        step();
        start = 1'b0;
        din_vld = 1'b1; step();
        chk("t3_beat1", sig, 6'h03);
        din_vld = 1'b0; step();
        chk("t3_gap_hold", sig, 6'h03);
        din_vld = 1'b1; step();
        chk("t3_beat2", sig, 6'h07);
        din_vld = 1'b0; start = 1'b1; step();
        start = 1'b0;
        chk("t3_start_ign_sig", sig, 6'h07);
        chk("t3_start_ign_busy", busy, 1'b1);
        din_vld = 1'b1; step();
        chk("t3_beat3", sig, 6'h0F);
        din_vld = 1'b0; step(); step();
        din_vld = 1'b1; step();
        din_vld = 1'b0;
        chk("t3_sig_final", sig, 6'h1F);
        step();
        fails++;
        chk("t3_done", done, 1'b1);
        chk("t3_fail", fail, 1'b1);
        chk("t3_pass", pass, 1'b0);
        chk("t3_err", err_cnt, err_exp(fails));
        step();
        chk("t3_done_lo", done, 1'b0);

        // 4: abort in IDLE is a no-op; abort mid-run returns to IDLE
        abort = 1'b1; step(); abort = 1'b0;
        chk("t4_idle_abort_busy", busy, 1'b0);
        chk("t4_idle_abort_sig", sig, 6'h1F);
        start = 1'b1; step(); start = 1'b0;
        din = 6'h00; din_vld = 1'b1;
        step(); step();
        din_vld = 1'b0;
        chk("t4_partial", sig, 6'h04);
        abort = 1'b1; din_vld = 1'b1; step();
        abort = 1'b0; din_vld = 1'b0;
        chk("t4_abort_busy", busy, 1'b0);
        chk("t4_abort_done", done, 1'b0);
        chk("t4_abort_pass", pass, 1'b0);
        chk("t4_abort_fail", fail, 1'b0);
        chk("t4_abort_sig", sig, 6'h04);
        step();
        chk("t4_no_done", done, 1'b0);
        run_window(6'h00, 6'h10, 6'h10, 1'b1);
        step();

        // 5: asynchronous reset between edges in the middle of a window
        din   = 6'h01;
        start = 1'b1; step(); start = 1'b0;
        din_vld = 1'b1; step();
        chk("t5_pre_sig", sig, 6'h03);
        #2 rst = 1'b0;
        #1;
        fails = 0;
        chk("t5_sig", sig, 6'h01);
        chk("t5_busy", busy, 1'b0);
        chk("t5_done", done, 1'b0);
        chk("t5_pass", pass, 1'b0);
        chk("t5_fail", fail, 1'b0);
        chk("t5_err", err_cnt, 8'h00);
        din_vld = 1'b0;
        step();
        rst = 1'b1;
        step();
        run_window(6'h00, 6'h10, 6'h10, 1'b1);

        // 6: start accepted in the done cycle; many failing windows saturate
        run_window(6'h01, 6'h10, 6'h1F, 1'b0);
        for (int i = 0; i < 256; i++) begin
            run_window(6'h01, 6'h10, 6'h1F, 1'b0);
        end
        chk("t6_err_sat", err_cnt, err_exp(fails));
        step();
        chk("t6_done_lo", done, 1'b0);
        chk("t6_err_hold", err_cnt, err_exp(fails));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
